dma_tx_sequencer: RTL and testbench



---
 rtl/dma_tx_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dma_tx_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_tx_sequencer.sv
// Block-transfer front end for the UART DMA write engine: streams cmd_len SRAM words
// one at a time through the single-word we/busy handshake. Define DMA_SEQ_ABORT_EN to add the abort input.
module dma_tx_sequencer #(
    parameter int unsigned SRAM_ADDR_W = 10,
    parameter int unsigned LEN_W       = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SRAM_ADDR_W-1:0] cmd_sram_addr,
    input  logic [6:0]             cmd_host_addr,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic                   sram_re,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [17:0]            sram_rdata,
    output logic [17:0]            dma_dat_w,
    output logic [6:0]             dma_dat_addr,
    output logic                   we,
    input  logic                   busy,
`ifdef DMA_SEQ_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   done,
    output logic                   active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WAIT_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [SRAM_ADDR_W-1:0] sram_ptr;
    logic [6:0]             host_ptr;
    logic [LEN_W-1:0]       remaining;
    logic [17:0]            dat_q;
    logic [6:0]             addr_q;
    logic                   active_q;
    logic                   cmd_ready_q;
    logic                   abort_pend_q;
    logic                   abort_pend_d;

    logic                   accept;
    logic                   word_done;
    logic                   abort_in;

`ifdef DMA_SEQ_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        word_done    = 1'b0;
        abort_pend_d = abort_pend_q;

        case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    accept  = 1'b1;
                    state_d = (cmd_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = abort_in ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = abort_in ? S_DONE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (abort_in) begin
                    state_d = S_DONE;
                end else if (!busy) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                abort_pend_d = abort_pend_q | abort_in;
                state_d      = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                abort_pend_d = abort_pend_q | abort_in;
                if (busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                abort_pend_d = abort_pend_q | abort_in;
                if (!busy) begin
                    // Word in flight has drained; a pending abort ends the command here.
                    word_done = 1'b1;
                    if ((remaining == LEN_W'(1)) || abort_pend_d) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_ptr     <= '0;
            host_ptr     <= '0;
            remaining    <= '0;
            dat_q        <= '0;
            addr_q       <= '0;
            active_q     <= 1'b0;
            cmd_ready_q  <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            cmd_ready_q  <= (state_d == S_IDLE);
            abort_pend_q <= abort_pend_d;

            if (accept) begin
                sram_ptr  <= cmd_sram_addr;
                host_ptr  <= cmd_host_addr;
                remaining <= cmd_len;
                active_q  <= 1'b1;
            end

            if (state_q == S_CAPTURE) begin
                dat_q  <= sram_rdata;
                addr_q <= host_ptr;
            end

            // Pointers wrap naturally at their register widths.
            if (word_done) begin
                remaining <= remaining - LEN_W'(1);
                sram_ptr  <= sram_ptr + SRAM_ADDR_W'(1);
                host_ptr  <= host_ptr + 7'd1;
            end

            if (state_q == S_DONE) begin
                active_q <= 1'b0;
            end
        end
    end

    always_comb begin
        sram_re      = (state_q == S_READ);
        we           = (state_q == S_ISSUE);
        done         = (state_q == S_DONE);
        sram_addr    = sram_ptr;
        dma_dat_w    = dat_q;
        dma_dat_addr = addr_q;
        active       = active_q;
        cmd_ready    = cmd_ready_q;
    end

endmodule

// File: tb/tb_dma_tx_sequencer.sv
// Self-checking bench for dma_tx_sequencer: SRAM and DMA-engine models plus a
// scoreboard of expected (data, host address) pairs per we pulse.
module tb_dma_tx_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_sram_addr;
    logic [6:0]  cmd_host_addr;
    logic [7:0]  cmd_len;
    logic        sram_re;
    logic [9:0]  sram_addr;
    logic [17:0] sram_rdata = '0;
    logic [17:0] dma_dat_w;
    logic [6:0]  dma_dat_addr;
    logic        we;
    logic        busy;
    logic        done;
    logic        active;
`ifdef DMA_SEQ_ABORT_EN
    logic        abort;
`endif

    dma_tx_sequencer #(
        .SRAM_ADDR_W(10),
        .LEN_W      (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_sram_addr(cmd_sram_addr),
        .cmd_host_addr(cmd_host_addr),
        .cmd_len      (cmd_len),
        .sram_re      (sram_re),
        .sram_addr    (sram_addr),
        .sram_rdata   (sram_rdata),
        .dma_dat_w    (dma_dat_w),
        .dma_dat_addr (dma_dat_addr),
        .we           (we),
        .busy         (busy),
`ifdef DMA_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .done         (done),
        .active       (active)
    );

    always #5 clk = ~clk;

    // SRAM: data valid one cycle after sram_re.
    logic [17:0] mem [1024];
    always @(posedge clk) begin
        if (sram_re) sram_rdata <= mem[sram_addr];
    end

    // DMA engine: busy rises the cycle after we and stays up busy_cycles cycles.
    int unsigned busy_cycles = 20;
    logic [7:0]  busy_cnt = '0;
    logic        busy_force = 1'b0;
    always @(posedge clk) begin
        if (we) busy_cnt <= busy_cycles[7:0];
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 8'd1;
    end
    assign busy = busy_force || (busy_cnt != 0);

    logic [24:0] sb [$];
    logic [24:0] exp_word;
    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (we) begin
                we_cnt++;
                chk("we_while_busy", 32'(busy), 32'd0);
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_word = sb.pop_front();
                    chk("dat_w", 32'(dma_dat_w), 32'(exp_word[24:7]));
                    chk("dat_addr", 32'(dma_dat_addr), 32'(exp_word[6:0]));
                end
            end
            if (sram_re) re_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] sa, input logic [6:0] ha, input logic [7:0] len,
                        input int nexp);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < nexp; i++) begin
            logic [9:0] a;
            logic [6:0] h;
            a = sa + 10'(i);
            h = ha + 7'(i);
            sb.push_back({mem[a], h});
        end
        cmd_valid     = 1'b1;
        cmd_sram_addr = sa;
        cmd_host_addr = ha;
        cmd_len       = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_we(input int target, input int budget);
        int n = 0;
        while (we_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("we_reached", 32'(we_cnt), 32'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, d0;
        for (int i = 0; i < 1024; i++) mem[i] = 18'(i * 37 + 5);
        mem[10'h010] = 18'h3FFFF;
        mem[10'h011] = 18'h00001;
        mem[10'h012] = 18'h12345;
        resetn        = 1'b0;
        cmd_valid     = 1'b0;
        cmd_sram_addr = '0;
        cmd_host_addr = '0;
        cmd_len       = '0;
`ifdef DMA_SEQ_ABORT_EN
        abort = 1'b0;
`endif

        // Reset state
        tick(); tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ctrl", 32'({we, sram_re, done, active}), 32'd0);
        chk("rst_data", 32'({dma_dat_w, dma_dat_addr, sram_addr}), 32'd0);
        resetn = 1'b1;
        tick();
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // Basic three-word command with latency checks
        w0 = we_cnt; d0 = done_cnt;
        send(10'h010, 7'h05, 8'd3, 3);
        chk("re_latency", 32'(sram_re), 32'd1);
        chk("active_on_accept", 32'(active), 32'd1);
        tick(); tick(); tick();
        chk("we_latency", 32'(we), 32'd1);
        wait_done(400);
        tick();
        chk("t1_active_low", 32'(active), 32'd0);
        chk("t1_we_count", 32'(we_cnt - w0), 32'd3);
        chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length command
        r0 = re_cnt; w0 = we_cnt;
        send(10'h050, 7'h00, 8'd0, 0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        chk("len0_done_once", 32'(done), 32'd0);
        chk("len0_ready_back", 32'(cmd_ready), 32'd1);
        chk("len0_active", 32'(active), 32'd0);
        chk("len0_no_re", 32'(re_cnt - r0), 32'd0);
        chk("len0_no_we", 32'(we_cnt - w0), 32'd0);

        // Host and SRAM pointer wrap
        busy_cycles = 3;
        w0 = we_cnt;
        send(10'h3FE, 7'h7E, 8'd4, 4);
        wait_done(400);
        tick();
        chk("wrap_we_count", 32'(we_cnt - w0), 32'd4);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Busy high at accept; extra command offered while active is ignored
        busy_force = 1'b1;
        w0 = we_cnt;
        send(10'h100, 7'h20, 8'd2, 2);
        for (int i = 0; i < 50; i++) begin
            cmd_valid = (i < 10);
            cmd_len   = 8'd7;
            if (i == 9) chk("ready_low_while_active", 32'(cmd_ready), 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        chk("no_we_while_busy_held", 32'(we_cnt - w0), 32'd0);
        busy_force = 1'b0;
        tick();
        chk("we_after_busy_fall", 32'(we), 32'd1);
        wait_done(400);
        tick();
        chk("busy_we_count", 32'(we_cnt - w0), 32'd2);
        chk("busy_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the second word's WAIT_LO
        busy_cycles = 10;
        w0 = we_cnt; d0 = done_cnt;
        send(10'h200, 7'h30, 8'd3, 3);
        wait_we(w0 + 2, 400);
        tick(); tick(); tick(); tick();
        resetn = 1'b0;
        #1;
        chk("midrst_ctrl", 32'({we, sram_re, done, active, cmd_ready}), 32'd0);
        chk("midrst_dat", 32'(dma_dat_w), 32'd0);
        chk("midrst_addr", 32'({dma_dat_addr, sram_addr}), 32'd0);
        sb.delete();
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        send(10'h020, 7'h10, 8'd2, 2);
        wait_done(400);
        tick();
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        chk("post_rst_done", 32'(done_cnt - d0), 32'd1);

`ifdef DMA_SEQ_ABORT_EN
        // Abort during word 2's WAIT_HI
        busy_cycles = 4;
        w0 = we_cnt; d0 = done_cnt;
        send(10'h300, 7'h40, 8'd5, 2);
        wait_we(w0 + 2, 400);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(400);
        tick();
        chk("abort_we_count", 32'(we_cnt - w0), 32'd2);
        chk("abort_done_count", 32'(done_cnt - d0), 32'd1);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
`endif

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
